// File: rtl/apb_subsystem_pkg.sv
// Shared widths, FSM state type and address map for the APB subsystem.
package apb_subsystem_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_PROT_WIDTH = 3;

    localparam int SLAVE_WORDS = 8;
    localparam logic [31:0] SLAVE0_BASE = 32'h0000_0000;
    localparam logic [31:0] SLAVE1_BASE = 32'h0000_0020;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

endpackage

// File: rtl/apb_slave_mem.sv
// Zero-wait APB4 slave: SLAVE_WORDS x DATA_WIDTH register bank with byte strobes.
module apb_slave_mem
    import apb_subsystem_pkg::*;
#(
    parameter int DATA_WIDTH   = APB_DATA_WIDTH,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int IDX_WIDTH    = $clog2(SLAVE_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [IDX_WIDTH-1:0]    pidx,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [STROBE_WIDTH-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    logic [DATA_WIDTH-1:0] mem [SLAVE_WORDS];
    logic                  wr_access;

    assign wr_access = psel && penable && pwrite;

    // NOTE: the bank must read back zero after reset, so it is a flop array with
    // an async clear rather than an inferred RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < SLAVE_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (wr_access) begin
            for (int i = 0; i < STROBE_WIDTH; i++) begin
                if (pstrb[i]) begin
                    mem[pidx][8*i +: 8] <= pwdata[8*i +: 8];
                end
            end
        end
    end

    assign prdata  = (psel && penable && !pwrite) ? mem[pidx] : '0;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;

endmodule

// File: rtl/apb_subsystem.sv
// Request-to-APB4 bridge with address decode onto two on-chip register banks;
// unmapped addresses complete immediately with an error and read data of zero.
module apb_subsystem
    import apb_subsystem_pkg::*;
#(
    parameter int ADDR_WIDTH   = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = APB_DATA_WIDTH,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int PROT_WIDTH   = APB_PROT_WIDTH
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   MADDR,
    input  logic [DATA_WIDTH-1:0]   MWDATA,
    input  logic [STROBE_WIDTH-1:0] MSTRB,
    input  logic                    MWRITE,
    input  logic                    MREQ,
    input  logic [PROT_WIDTH-1:0]   MPROT,
    output logic                    MSLVERR,
    output logic [DATA_WIDTH-1:0]   MRDATA,
    output logic                    MREADY
);

    localparam int IDX_WIDTH = $clog2(SLAVE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE0 = ADDR_WIDTH'(SLAVE0_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(SLAVE1_BASE);

    state_t                  state;
    logic                    psel, penable, pready, pslverr, capture;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata, prdata, prdata0, prdata1, mrdata_q;
    logic [STROBE_WIDTH-1:0] strb_q, pstrb;
    logic                    pwrite;
    logic [PROT_WIDTH-1:0]   pprot;
    logic                    hit0, hit1, no_slave;
    logic                    pready0, pready1, pslverr0, pslverr1;
    logic                    unused_bits;

    // A new request is latched whenever the FSM is about to enter SETUP.
    assign capture = MREQ && ((state == IDLE) || (state == ACCESS && pready));

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            case (state)
                IDLE: if (MREQ) begin
                    state <= SETUP;
                    psel  <= 1'b1;
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: if (pready) begin
                    penable <= 1'b0;
                    state   <= MREQ ? SETUP : IDLE;
                    psel    <= MREQ;
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            paddr  <= '0;
            pwdata <= '0;
            strb_q <= '0;
            pwrite <= 1'b0;
            pprot  <= '0;
        end else if (capture) begin
            paddr  <= MADDR;
            pwdata <= MWDATA;
            strb_q <= MSTRB;
            pwrite <= MWRITE;
            pprot  <= MPROT;
        end
    end

    assign pstrb    = pwrite ? strb_q : '0;
    assign hit0     = paddr[ADDR_WIDTH-1:5] == BASE0[ADDR_WIDTH-1:5];
    assign hit1     = paddr[ADDR_WIDTH-1:5] == BASE1[ADDR_WIDTH-1:5];
    assign no_slave = !hit0 && !hit1;

    apb_slave_mem #(.DATA_WIDTH(DATA_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)) u_slave0 (
        .clk(PCLK), .rst(PRESETn), .psel(psel && hit0), .penable(penable), .pwrite(pwrite),
        .pidx(paddr[2 +: IDX_WIDTH]), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_mem #(.DATA_WIDTH(DATA_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)) u_slave1 (
        .clk(PCLK), .rst(PRESETn), .psel(psel && hit1), .penable(penable), .pwrite(pwrite),
        .pidx(paddr[2 +: IDX_WIDTH]), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    // Unmapped addresses are answered by the bridge itself: ready, error, data zero.
    assign pready  = no_slave || (hit0 ? pready0 : pready1);
    assign pslverr = no_slave || (hit0 ? pslverr0 : pslverr1);
    assign prdata  = hit0 ? prdata0 : (hit1 ? prdata1 : '0);

    assign MREADY  = (state == ACCESS) && pready;
    assign MSLVERR = MREADY && pslverr;

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            mrdata_q <= '0;
        end else if (MREADY && !pwrite) begin
            mrdata_q <= prdata;
        end
    end

    assign MRDATA = (MREADY && !pwrite) ? prdata : mrdata_q;

    // Protection bits have no slave-side meaning here and byte offsets are ignored.
    assign unused_bits = ^{pprot, paddr[1:0]};

endmodule

// File: tb/tb_apb_subsystem.sv
// Randomised self-checking bench for apb_subsystem against a word-array model.
module tb_apb_subsystem;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] MADDR;
    logic [31:0] MWDATA;
    logic [3:0]  MSTRB;
    logic        MWRITE;
    logic        MREQ;
    logic [2:0]  MPROT;
    logic        MSLVERR;
    logic [31:0] MRDATA;
    logic        MREADY;

    apb_subsystem dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .MADDR(MADDR), .MWDATA(MWDATA), .MSTRB(MSTRB),
        .MWRITE(MWRITE), .MREQ(MREQ), .MPROT(MPROT), .MSLVERR(MSLVERR),
        .MRDATA(MRDATA), .MREADY(MREADY)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem0 [8];
    logic [31:0] mem1 [8];
    logic [31:0] last_rd;

    function automatic void model_reset();
        for (int w = 0; w < 8; w++) begin
            mem0[w] = '0;
            mem1[w] = '0;
        end
        last_rd = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'h20) return mem0[a[4:2]];
        if (a < 32'h40) return mem1[a[4:2]];
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] w;
        if (a >= 32'h40) return;
        w = model_read(a);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        if (a < 32'h20) mem0[a[4:2]] = w;
        else            mem1[a[4:2]] = w;
    endfunction

    // Called at a falling edge; returns at the falling edge where MREADY is seen.
    task automatic do_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic wr, input bit hold, input string tag);
        int          n;
        logic [31:0] exp_d;
        logic        exp_err;
        MADDR  = a;
        MWDATA = d;
        MSTRB  = s;
        MWRITE = wr;
        MPROT  = 3'($urandom);
        MREQ   = 1'b1;
        @(negedge PCLK);
        n = 1;
        while (MREADY !== 1'b1 && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL %s latency addr=%h: got %0d cycles, expected 2", tag, a, n);
        end
        exp_err = (a >= 32'h40);
        exp_d   = wr ? last_rd : model_read(a);
        checks++;
        if (MSLVERR !== exp_err) begin
            errors++;
            $display("FAIL %s slverr addr=%h: got %b, expected %b", tag, a, MSLVERR, exp_err);
        end
        checks++;
        if (MRDATA !== exp_d) begin
            errors++;
            $display("FAIL %s rdata addr=%h wr=%b: got %h, expected %h", tag, a, wr, MRDATA, exp_d);
        end
        if (wr) model_write(a, d, s);
        else    last_rd = exp_d;
        if (!hold) begin
            MREQ   = 1'b0;
            MADDR  = $urandom;
            MWDATA = $urandom;
            MSTRB  = 4'($urandom);
            MWRITE = 1'($urandom);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge PCLK);
        checks++;
        if (MREADY !== 1'b0 || MSLVERR !== 1'b0 || MRDATA !== last_rd) begin
            errors++;
            $display("FAIL %s idle: got ready=%b err=%b rdata=%h, expected 0 0 %h",
                     tag, MREADY, MSLVERR, MRDATA, last_rd);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        MREQ = 1'b0; MADDR = '0; MWDATA = '0; MSTRB = '0; MWRITE = 1'b0; MPROT = '0;
        model_reset();
        repeat (2) @(negedge PCLK);
        checks++;
        if (MREADY !== 1'b0 || MRDATA !== 32'h0 || MSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got ready=%b rdata=%h err=%b, expected 0 0 0",
                     MREADY, MRDATA, MSLVERR);
        end
        PRESETn = 1'b0;
        idle_check("reset_release");
        do_xfer(32'h00, 32'h0, 4'h0, 1'b0, 1'b0, "reset_read0");
        idle_check("reset_after_read");
    endtask

    task automatic test_directed();
        do_xfer(32'h1F, 32'h0000_0055, 4'hF, 1'b1, 1'b1, "wr_1f");
        do_xfer(32'h3F, 32'h8800_0055, 4'h8, 1'b1, 1'b0, "b2b_wr_3f");
        repeat (3) idle_check("gap");
        do_xfer(32'h1F, 32'h0, 4'h0, 1'b0, 1'b0, "rd_1f");
        idle_check("rd_1f_hold");
        do_xfer(32'h3F, 32'h0, 4'hF, 1'b0, 1'b0, "rd_3f");
        idle_check("rd_3f_hold");
    endtask

    task automatic test_error();
        do_xfer(32'h40, 32'h1234_5678, 4'hF, 1'b1, 1'b0, "wr_oob");
        idle_check("wr_oob_idle");
        do_xfer(32'h1F, 32'h0, 4'h0, 1'b0, 1'b1, "rd_1f_after_oob");
        do_xfer(32'h3F, 32'h0, 4'h0, 1'b0, 1'b1, "rd_3f_after_oob");
        do_xfer(32'h40, 32'h0, 4'h0, 1'b0, 1'b0, "rd_oob");
        idle_check("rd_oob_idle");
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          hold;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                6:       a = $urandom_range(32'h40, 32'h7F);
                7:       a = $urandom | 32'h100;
                default: a = $urandom_range(0, 32'h3F);
            endcase
            hold = (i < 79) && ($urandom_range(0, 2) != 0);
            do_xfer(a, $urandom, 4'($urandom), 1'($urandom), hold, "rand");
            if (!hold && $urandom_range(0, 1) == 1) idle_check("rand_gap");
        end
        for (int w = 0; w < 16; w++) begin
            do_xfer(32'(w * 4), 32'h0, 4'h0, 1'b0, (w != 15), "sweep");
        end
        idle_check("sweep_idle");
    endtask

    task automatic test_reset_mid();
        do_xfer(32'h04, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, "pre_wr_04");
        do_xfer(32'h04, 32'h0, 4'h0, 1'b0, 1'b0, "pre_rd_04");
        MADDR = 32'h04; MWDATA = 32'hA5A5_A5A5; MSTRB = 4'hF; MWRITE = 1'b1; MREQ = 1'b1;
        repeat (2) @(negedge PCLK);
        checks++;
        if (MREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_access_ready: got %b, expected 1", MREADY);
        end
        PRESETn = 1'b1;
        #1;
        model_reset();
        checks++;
        if (MREADY !== 1'b0 || MRDATA !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b rdata=%h, expected 0 0", MREADY, MRDATA);
        end
        MREQ = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b0;
        idle_check("mid_reset_release");
        do_xfer(32'h04, 32'h0, 4'h0, 1'b0, 1'b0, "rd_04_after_reset");
        idle_check("final_idle");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_error();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
